l1ca_correlator: RTL and testbench
==================================

L1CA_CORRELATOR -- requirements
Module: l1ca_correlator

Interface
REQ-001 Parameter EPL_SPACING, default 2, early-to-prompt and prompt-to-late delay in accepted samples (range 1..8).
REQ-002 Parameter ACC_W, default 24, accumulator and dump width in bits, signed.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 nrst  in  1  asynchronous active-low reset.
REQ-005 clear  in  1  synchronous flush of delay line, accumulators and dump state.
REQ-006 sample_valid  in  1  qualifies sample_i/sample_q/code/epoch this cycle.
REQ-007 sample_i, sample_q  in  sample_t (4, signed)  baseband I/Q sample.
REQ-008 code  in  1  early replica chip from l1ca_code (0 maps to +1, 1 maps to -1).
REQ-009 epoch  in  1  l1ca_code epoch flag, aligned with code.
REQ-010 dump_ready  in  1  consumer accepts dump.
REQ-011 dump_valid  out  1  dump registers hold a completed period.
REQ-012 dump_ie, dump_qe, dump_ip, dump_qp, dump_il, dump_ql  out  ACC_W each  early/prompt/late I/Q sums.
REQ-013 overrun  out  1  sticky: a dump was lost.

Function
REQ-014 On each sample_valid, code and epoch SHALL shift into a 2*EPL_SPACING-deep delay line; early = current code, prompt = code delayed EPL_SPACING accepted samples, late = delayed 2*EPL_SPACING; prompt_epoch = epoch delayed EPL_SPACING.
REQ-015 Delay line SHALL NOT advance when sample_valid is low.
REQ-016 Per accepted sample, each of the six accumulators SHALL add sample_x when its replica bit is 0, subtract it when 1.
REQ-017 When an accepted sample has prompt_epoch = 1, the six pre-update sums SHALL be copied to dump registers and each accumulator SHALL be loaded with that sample's product (no sample dropped or double-counted).
REQ-018 dump_valid SHALL rise the cycle after the dumping sample and stay high until a cycle with dump_valid and dump_ready both high; dump registers SHALL be stable while dump_valid is high.
REQ-019 A new dump while dump_valid is high and dump_ready is low SHALL overwrite dump registers, keep dump_valid high, and set overrun.
REQ-020 A dump coinciding with a handshake cycle SHALL not set overrun; dump_valid stays high with new data.
REQ-021 Delay-line entries not yet filled since reset/clear SHALL read code 0, epoch 0.
REQ-022 Without saturation, accumulators SHALL wrap modulo 2^ACC_W.
REQ-023 clear SHALL zero delay line, accumulators, dump registers, dump_valid and overrun next edge; clear overrides a simultaneous sample_valid.
REQ-024 overrun SHALL clear only on reset or clear.

Reset
REQ-025 nrst low SHALL asynchronously force all accumulators, dump registers, delay line, dump_valid and overrun to 0.
REQ-026 Reset mid-period SHALL discard the partial sum; the first dump after reset covers samples from reset release to the first prompt_epoch.

Configuration
REQ-027 Macro CORR_SATURATE_EN: when defined, each accumulator SHALL clamp at +(2^(ACC_W-1))-1 / -(2^(ACC_W-1)) instead of wrapping; when undefined, wrap per REQ-022.

Structure
REQ-028 sample_t (logic signed [3:0]), CORR_ACC_W default and corr_dump_t (six ACC_W fields) SHALL live in common_gnss_types_pkg alongside gps_chip_t.
REQ-029 One sub-module, corr_accum (single signed accumulate/dump lane with optional saturation), SHALL be instantiated six times.

Verification
REQ-030 Constant sample_i=+3, sample_q=0, code=0 all samples, epoch every 100 samples, EPL_SPACING=2 -> each steady-state dump_ip=dump_ie=dump_il=300, Q dumps 0.
REQ-031 l1ca_code SV1 driving code/epoch, sample_i = +1 when code=0 else -1 (one sample per chip) -> dump_ip=1023, dump_ie and dump_il equal to SV1 autocorrelation at lag +/-2 (-1, -65 or 63).
REQ-032 dump_ready held low across two epochs -> overrun=1 after second dump, dump registers hold second period; dump_ready=1 -> dump_valid drops next cycle.
REQ-033 sample_valid toggling every other cycle -> sums identical to REQ-030 (gaps ignored).
REQ-034 clear asserted at sample 50 of a period -> all outputs 0 next cycle; next dump covers only post-clear samples.
REQ-035 CORR_SATURATE_EN, ACC_W=8, sample_i=+7, code=0, 100 samples -> dump_ip=127; without macro -> dump_ip=700 mod 256 as signed (-68).

Source files
------------

// File: rtl/common_gnss_types_pkg.sv
// Shared GNSS front-end types: chip, baseband sample and correlator dump payload.
package common_gnss_types_pkg;

  typedef logic gps_chip_t;
  typedef logic signed [3:0] sample_t;

  localparam int unsigned CORR_ACC_W = 24;

  typedef struct packed {
    logic signed [CORR_ACC_W-1:0] ie;
    logic signed [CORR_ACC_W-1:0] qe;
    logic signed [CORR_ACC_W-1:0] ip;
    logic signed [CORR_ACC_W-1:0] qp;
    logic signed [CORR_ACC_W-1:0] il;
    logic signed [CORR_ACC_W-1:0] ql;
  } corr_dump_t;

endpackage

// File: rtl/corr_accum.sv
// One signed accumulate-and-dump lane. CORR_SATURATE_EN selects clamping
// instead of modulo wrap on the running sum.
module corr_accum
  import common_gnss_types_pkg::*;
#(
  parameter int unsigned ACC_W = CORR_ACC_W
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    neg,
  input  logic                    dump,
  input  sample_t                 sample,
  output logic signed [ACC_W-1:0] dump_val
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] dump_q, dump_d;
  logic signed [ACC_W-1:0] prod, sum;

  always_comb begin
    prod = neg ? -ACC_W'(sample) : ACC_W'(sample);
  end

`ifdef CORR_SATURATE_EN
  localparam int unsigned WIDE_W = ACC_W + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [WIDE_W-1:0] wide;

  // Extra guard bit exposes overflow; clamp toward the overflow direction.
  always_comb begin
    wide = WIDE_W'(acc_q) + WIDE_W'(prod);
    if (wide[ACC_W] != wide[ACC_W-1]) sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else                              sum = wide[ACC_W-1:0];
  end
`else
  always_comb begin
    sum = acc_q + prod;
  end
`endif

  // Dumping sample seeds the next period so no sample is lost or counted twice.
  always_comb begin
    acc_d  = acc_q;
    dump_d = dump_q;
    if (clear) begin
      acc_d  = '0;
      dump_d = '0;
    end else if (en) begin
      if (dump) begin
        dump_d = acc_q;
        acc_d  = prod;
      end else begin
        acc_d  = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q  <= '0;
      dump_q <= '0;
    end else begin
      acc_q  <= acc_d;
      dump_q <= dump_d;
    end
  end

  assign dump_val = dump_q;

endmodule

// File: rtl/l1ca_correlator.sv
// Early/prompt/late L1 C/A correlator with valid/ready dump and sticky overrun.
// Accumulator saturation is enabled by defining CORR_SATURATE_EN.
module l1ca_correlator
  import common_gnss_types_pkg::*;
#(
  parameter int unsigned EPL_SPACING = 2,
  parameter int unsigned ACC_W       = CORR_ACC_W
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  sample_t                 sample_i,
  input  sample_t                 sample_q,
  input  logic                    code,
  input  logic                    epoch,
  input  logic                    dump_ready,
  output logic                    dump_valid,
  output logic signed [ACC_W-1:0] dump_ie,
  output logic signed [ACC_W-1:0] dump_qe,
  output logic signed [ACC_W-1:0] dump_ip,
  output logic signed [ACC_W-1:0] dump_qp,
  output logic signed [ACC_W-1:0] dump_il,
  output logic signed [ACC_W-1:0] dump_ql,
  output logic                    overrun
);

  localparam int unsigned DL_W = 2 * EPL_SPACING;

  logic [DL_W-1:0]        code_dl_q, code_dl_d;
  logic [EPL_SPACING-1:0] epoch_dl_q, epoch_dl_d;
  logic                   dump_valid_q, dump_valid_d;
  logic                   overrun_q, overrun_d;
  gps_chip_t              early, prompt, late;
  logic                   prompt_epoch, dump_evt;

  // Bit k of each delay line holds the value accepted k+1 samples ago.
  always_comb begin
    early        = code;
    prompt       = code_dl_q[EPL_SPACING-1];
    late         = code_dl_q[DL_W-1];
    prompt_epoch = epoch_dl_q[EPL_SPACING-1];
    dump_evt     = sample_valid & ~clear & prompt_epoch;
  end

  always_comb begin
    code_dl_d    = code_dl_q;
    epoch_dl_d   = epoch_dl_q;
    dump_valid_d = dump_valid_q;
    overrun_d    = overrun_q;
    if (clear) begin
      code_dl_d    = '0;
      epoch_dl_d   = '0;
      dump_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (sample_valid) begin
        code_dl_d  = DL_W'({code_dl_q, code});
        epoch_dl_d = EPL_SPACING'({epoch_dl_q, epoch});
      end
      // A dump landing on a pending, unaccepted dump loses the older one.
      if (dump_evt) begin
        dump_valid_d = 1'b1;
        if (dump_valid_q && !dump_ready) overrun_d = 1'b1;
      end else if (dump_valid_q && dump_ready) begin
        dump_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      code_dl_q    <= '0;
      epoch_dl_q   <= '0;
      dump_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      code_dl_q    <= code_dl_d;
      epoch_dl_q   <= epoch_dl_d;
      dump_valid_q <= dump_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dump_valid = dump_valid_q;
  assign overrun    = overrun_q;

  corr_accum #(.ACC_W(ACC_W)) u_ie (
    .clk(clk), .nrst(nrst), .clear(clear), .en(sample_valid), .neg(early),
    .dump(prompt_epoch), .sample(sample_i), .dump_val(dump_ie));
  corr_accum #(.ACC_W(ACC_W)) u_qe (
    .clk(clk), .nrst(nrst), .clear(clear), .en(sample_valid), .neg(early),
    .dump(prompt_epoch), .sample(sample_q), .dump_val(dump_qe));
  corr_accum #(.ACC_W(ACC_W)) u_ip (
    .clk(clk), .nrst(nrst), .clear(clear), .en(sample_valid), .neg(prompt),
    .dump(prompt_epoch), .sample(sample_i), .dump_val(dump_ip));
  corr_accum #(.ACC_W(ACC_W)) u_qp (
    .clk(clk), .nrst(nrst), .clear(clear), .en(sample_valid), .neg(prompt),
    .dump(prompt_epoch), .sample(sample_q), .dump_val(dump_qp));
  corr_accum #(.ACC_W(ACC_W)) u_il (
    .clk(clk), .nrst(nrst), .clear(clear), .en(sample_valid), .neg(late),
    .dump(prompt_epoch), .sample(sample_i), .dump_val(dump_il));
  corr_accum #(.ACC_W(ACC_W)) u_ql (
    .clk(clk), .nrst(nrst), .clear(clear), .en(sample_valid), .neg(late),
    .dump(prompt_epoch), .sample(sample_q), .dump_val(dump_ql));

endmodule

// File: tb/tb_l1ca_correlator.sv
// Randomized and directed bench for l1ca_correlator against a history-based model.
module tb_l1ca_correlator;
  import common_gnss_types_pkg::*;

  localparam int unsigned SP = 3;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic nrst, clear, sample_valid, code, epoch, dump_ready;
  sample_t sample_i, sample_q;
  logic dump_valid, overrun;
  logic signed [AW-1:0] dump_ie, dump_qe, dump_ip, dump_qp, dump_il, dump_ql;

  int checks = 0;
  int failures = 0;

  bit     hist_c[$];
  bit     hist_e[$];
  longint m_acc[6];
  longint m_dmp[6];
  bit     m_valid, m_ovr;

  always #5 clk = ~clk;

  l1ca_correlator #(.EPL_SPACING(SP), .ACC_W(AW)) dut (
    .clk(clk), .nrst(nrst), .clear(clear), .sample_valid(sample_valid),
    .sample_i(sample_i), .sample_q(sample_q), .code(code), .epoch(epoch),
    .dump_ready(dump_ready), .dump_valid(dump_valid),
    .dump_ie(dump_ie), .dump_qe(dump_qe), .dump_ip(dump_ip),
    .dump_qp(dump_qp), .dump_il(dump_il), .dump_ql(dump_ql),
    .overrun(overrun));

  task automatic check_val(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint fold(input longint x);
    longint m, hi, lo, r;
    m  = longint'(1) << AW;
    hi = (m / 2) - 1;
    lo = -(m / 2);
`ifdef CORR_SATURATE_EN
    r = (x > hi) ? hi : ((x < lo) ? lo : x);
`else
    r = x % m;
    if (r < 0) r += m;
    if (r > hi) r -= m;
`endif
    return r;
  endfunction

  function automatic void model_reset();
    hist_c.delete();
    hist_e.delete();
    for (int k = 0; k < 6; k++) begin
      m_acc[k] = 0;
      m_dmp[k] = 0;
    end
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endfunction

  // Replica chips are looked up from the history of accepted samples.
  function automatic void model_clock(input bit cl, input bit sv, input int si, input int sq,
                                      input bit cd, input bit ep, input bit rdy);
    bit rep[3];
    bit pe, hs, dumped;
    int n, s, p;
    if (cl) begin
      model_reset();
      return;
    end
    hs = m_valid && rdy;
    dumped = 1'b0;
    if (sv) begin
      n = hist_c.size();
      rep[0] = cd;
      rep[1] = (n >= SP)     ? hist_c[n - SP]     : 1'b0;
      rep[2] = (n >= 2 * SP) ? hist_c[n - 2 * SP] : 1'b0;
      pe     = (n >= SP)     ? hist_e[n - SP]     : 1'b0;
      for (int k = 0; k < 6; k++) begin
        s = (k % 2 == 0) ? si : sq;
        p = rep[k / 2] ? -s : s;
        if (pe) begin
          m_dmp[k] = m_acc[k];
          m_acc[k] = p;
        end else begin
          m_acc[k] = fold(m_acc[k] + p);
        end
      end
      hist_c.push_back(cd);
      hist_e.push_back(ep);
      if (hist_c.size() > 2 * SP) begin
        void'(hist_c.pop_front());
        void'(hist_e.pop_front());
      end
      dumped = pe;
    end
    if (dumped) begin
      if (m_valid && !rdy) m_ovr = 1'b1;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic compare_all();
    check_val("dump_valid", longint'(dump_valid), longint'(m_valid));
    check_val("overrun", longint'(overrun), longint'(m_ovr));
    check_val("dump_ie", longint'(dump_ie), m_dmp[0]);
    check_val("dump_qe", longint'(dump_qe), m_dmp[1]);
    check_val("dump_ip", longint'(dump_ip), m_dmp[2]);
    check_val("dump_qp", longint'(dump_qp), m_dmp[3]);
    check_val("dump_il", longint'(dump_il), m_dmp[4]);
    check_val("dump_ql", longint'(dump_ql), m_dmp[5]);
  endtask

  task automatic step(input bit cl, input bit sv, input int si, input int sq,
                      input bit cd, input bit ep, input bit rdy);
    clear        = cl;
    sample_valid = sv;
    sample_i     = sample_t'(si);
    sample_q     = sample_t'(sq);
    code         = cd;
    epoch        = ep;
    dump_ready   = rdy;
    @(posedge clk);
    model_clock(cl, sv, si, sq, cd, ep, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    #2 nrst = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    longint wrap_exp;
    nrst = 1'b0;
    clear = 1'b0; sample_valid = 1'b0; code = 1'b0; epoch = 1'b0; dump_ready = 1'b0;
    sample_i = '0; sample_q = '0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    nrst = 1'b1;

    // Constant +3, ready held low: later dumps overwrite and flag overrun.
    for (int n = 0; n < 250; n++) step(1'b0, 1'b1, 3, 0, 1'b0, (n % 100) == 0, 1'b0);
    check_val("const_ip", longint'(dump_ip), 300);
    check_val("const_ie", longint'(dump_ie), 300);
    check_val("const_il", longint'(dump_il), 300);
    check_val("const_qp", longint'(dump_qp), 0);
    check_val("const_ovr", longint'(overrun), 1);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check_val("drop_valid", longint'(dump_valid), 0);

    // Same pattern with a gap every other cycle.
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 500; n++)
      step(1'b0, (n % 2) == 0, 3, 0, 1'b0, ((n % 2) == 0) && (((n / 2) % 100) == 0), 1'b1);
    check_val("gap_ip", longint'(dump_ip), 300);
    check_val("gap_ovr", longint'(overrun), 0);

    // Long period of +7 overflows the 12-bit accumulator.
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 820; n++) step(1'b0, 1'b1, 7, -2, 1'b0, (n % 400) == 0, 1'b1);
`ifdef CORR_SATURATE_EN
    wrap_exp = 2047;
`else
    wrap_exp = -1296;
`endif
    check_val("wrap_ip", longint'(dump_ip), wrap_exp);
    check_val("wrap_ie", longint'(dump_ie), wrap_exp);

    // Clear in the middle of a period, overriding a valid sample.
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++) step(1'b0, 1'b1, 3, 1, 1'b0, (n % 100) == 0, 1'b0);
    step(1'b1, 1'b1, 3, 1, 1'b0, 1'b1, 1'b0);
    check_val("clr_ip", longint'(dump_ip), 0);
    check_val("clr_valid", longint'(dump_valid), 0);
    check_val("clr_ovr", longint'(overrun), 0);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 3, 1, 1'b0, n == 10, 1'b0);
    check_val("post_clr_ip", longint'(dump_ip), 39);
    check_val("post_clr_qp", longint'(dump_qp), 13);

    // Random traffic with a mid-run asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step(($urandom % 200) == 0, ($urandom % 4) != 0,
           int'($urandom_range(15, 0)) - 8, int'($urandom_range(15, 0)) - 8,
           1'($urandom), ($urandom % 30) == 0, ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
